// File: rtl/wb_master_xfer_if.sv
// Requester and Wishbone signal bundle for wb_master_xfer.
// The master modport is the engine's view; the slave modport is the environment's view.
`ifndef DAT_WIDTH
`define DAT_WIDTH 64
`endif

interface wb_master_xfer_if;
  logic                  req_i;
  logic                  req_we_i;
  logic [15:0]           req_adr_i;
  logic [`DAT_WIDTH-1:0] req_dat_i;
  logic                  ready_o;
  logic                  done_o;
  logic                  err_o;
  logic [`DAT_WIDTH-1:0] rdata_o;
  logic                  m_cyc_o;
  logic                  m_stb_o;
  logic                  m_we_o;
  logic [15:0]           m_adr_o;
  logic [`DAT_WIDTH-1:0] m_dat_o;
  logic [`DAT_WIDTH-1:0] m_dat_i;
  logic                  m_ack_i;
  logic                  m_err_i;

  modport master (
    input  req_i, req_we_i, req_adr_i, req_dat_i, m_dat_i, m_ack_i, m_err_i,
    output ready_o, done_o, err_o, rdata_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o
  );

  modport slave (
    output req_i, req_we_i, req_adr_i, req_dat_i, m_dat_i, m_ack_i, m_err_i,
    input  ready_o, done_o, err_o, rdata_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o
  );
endinterface

// File: rtl/wb_master_xfer.sv
// Single-transfer Wishbone classic master: one read/write per request, ok/err status.
// Optional bus timeout enabled by defining WB_MASTER_TIMEOUT_EN.
`ifndef DAT_WIDTH
`define DAT_WIDTH 64
`endif

module wb_master_xfer #(
  parameter int TIMEOUT   = 16,
  parameter int ADR_ALIGN = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  wb_master_xfer_if.master    bus
);
  localparam int          DW         = `DAT_WIDTH;
  localparam logic [15:0] ALIGN_MASK = 16'((1 << ADR_ALIGN) - 1);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("wb_master_xfer: TIMEOUT must be at least 1");
  end

  typedef enum logic {IDLE, BUS} state_e;

  state_e          state_q, state_d;
  logic            ready_q, ready_d;
  logic            done_q,  done_d;
  logic            err_q,   err_d;
  logic            cyc_q,   cyc_d;
  logic            we_q,    we_d;
  logic [15:0]     adr_q,   adr_d;
  logic [DW-1:0]   dat_q,   dat_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            misaligned;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  assign misaligned = |(bus.req_adr_i & ALIGN_MASK);

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
`ifdef WB_MASTER_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          if (misaligned) begin
            // Rejected without touching the bus: address/data lines keep their old values.
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d = BUS;
            ready_d = 1'b0;
            cyc_d   = 1'b1;
            we_d    = bus.req_we_i;
            adr_d   = bus.req_adr_i;
            dat_d   = bus.req_dat_i;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end
        end
      end
      BUS: begin
        if (bus.m_err_i || bus.m_ack_i) begin
          // Error wins over a simultaneous ack; errored reads leave rdata alone.
          state_d = IDLE;
          ready_d = 1'b1;
          done_d  = 1'b1;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = bus.m_err_i;
          if (!bus.m_err_i && !we_q) rdata_d = bus.m_dat_i;
        end
`ifdef WB_MASTER_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          ready_d = 1'b1;
          done_d  = 1'b1;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign bus.ready_o = ready_q;
  assign bus.done_o  = done_q;
  assign bus.err_o   = err_q;
  assign bus.rdata_o = rdata_q;
  assign bus.m_cyc_o = cyc_q;
  assign bus.m_stb_o = cyc_q;
  assign bus.m_we_o  = we_q;
  assign bus.m_adr_o = adr_q;
  assign bus.m_dat_o = dat_q;

endmodule

// File: doc/wb_master_xfer.md
# wb_master_xfer

Single-transfer Wishbone master engine: accepts one read or write request from a CPU-side requester, runs the matching Wishbone classic cycle against a slave (ROM, RAM, peripherals), and returns read data plus an ok/error status. It sits between the core's fetch/load-store logic and the bus, and is the initiator counterpart to the registered-ack slaves on the bus (ack/err asserted the cycle after stb, held while stb is high).

## Interface
Parameters:
- TIMEOUT, 16: bus cycles allowed in BUS state before a forced error (used only with timeout enabled).
- ADR_ALIGN, 3: log2 of the transfer size in bytes; the low ADR_ALIGN address bits must be zero.

Ports (clock and reset first):
- clk_i  in  1  system clock; every flop is on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  1  request strobe; accepted only when ready_o=1.
- req_we_i  in  1  1 = write, 0 = read.
- req_adr_i  in  16  byte address.
- req_dat_i  in  `DAT_WIDTH  write data.
- ready_o  out  1  engine idle, can accept req_i.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  valid with done_o: 1 = transfer failed.
- rdata_o  out  `DAT_WIDTH  read data, valid from done_o until next accepted request.
- m_cyc_o, m_stb_o, m_we_o  out  1 each  Wishbone cycle, strobe, write enable.
- m_adr_o  out  16  Wishbone address.
- m_dat_o  out  `DAT_WIDTH  Wishbone write data.
- m_dat_i  in  `DAT_WIDTH  Wishbone read data.
- m_ack_i, m_err_i  in  1 each  Wishbone acknowledge / error.

## Operation
- States: IDLE, BUS.
- IDLE: ready_o=1. On req_i: latch we/adr/dat.
  - Misaligned address (any low ADR_ALIGN bit set): no bus cycle; next cycle done_o=1, err_o=1, stay IDLE.
  - Otherwise: go to BUS; m_cyc_o=m_stb_o=1, m_we_o/m_adr_o/m_dat_o driven from latches.
- BUS: ready_o=0; outputs held stable. Samples m_ack_i/m_err_i each cycle.
  - m_err_i=1 (with or without ack): terminate, err_o=1. Error wins over ack.
  - m_ack_i=1 only: terminate, err_o=0; on read, rdata_o <= m_dat_i.
  - Terminate = next edge: cyc/stb/we low, done_o=1 for one cycle, state IDLE.
- req_i while ready_o=0 is ignored (not queued).
- rdata_o unchanged on writes and on errored reads.
- m_cyc_o and m_stb_o always equal (single transfers only).

## Timing
- Reset values: ready_o=1, done_o=0, err_o=0, rdata_o=0, m_cyc_o=m_stb_o=m_we_o=0, m_adr_o=0, m_dat_o=0; state IDLE; timeout counter 0.
- Request in cycle N → stb high in N+1. Registered-ack slave acks in N+2 → done_o, stb low in N+3; ready_o=1 in N+3. Minimum latency request→done: 3 cycles.
- New request in N+3 → stb in N+4: stb is low for at least one full cycle between transfers, so registered slaves return to idle.
- Misaligned: request N → done_o/err_o in N+1, bus untouched.
- All outputs registered; no combinational path from m_ack_i/m_err_i to any output.
- Reset mid-BUS: next edge all outputs at reset values, no done_o pulse.

## Configuration
- Macro WB_MASTER_TIMEOUT_EN.
- Defined: counter clears on entering BUS, increments each BUS cycle without ack/err; when it reaches TIMEOUT-1 with no response, terminate next edge with done_o=1, err_o=1. Response in the same cycle as the limit takes priority over timeout.
- Undefined: no counter; BUS waits indefinitely for ack/err.

## Test plan
- Read 0x0000 from ROM slave: req at cycle 0 → stb cycles 1-2, done_o cycle 3, err_o=0, rdata_o=0x0204000000200420.
- Write 0x0008 to ROM (req_we_i=1, data 0x1234): slave asserts err → done_o=1, err_o=1, rdata_o unchanged.
- Misaligned read 0x0003 → done_o/err_o one cycle later, m_cyc_o never asserted.
- Back-to-back reads 0x0008 then 0x0038 (second req on first done cycle) → rdata 0x0208000000001cc0 then 0xfe00000000000000, stb low exactly one cycle between.
- WB_MASTER_TIMEOUT_EN, TIMEOUT=16, slave never responds → done_o/err_o=1 exactly 16 cycles after stb rose; without macro, stb stays high 100+ cycles.
- rst_i asserted cycle 2 of a read → cycle 3 all outputs at reset values, no done_o; subsequent read completes normally.
